// File: rtl/cv32e41s_instr_obi_arbiter_pkg.sv
// Shared types and constants for the instruction-side OBI arbiter.
package cv32e41s_instr_obi_arbiter_pkg;

    // One record per accepted transaction: who issued it and whether its
    // response must be swallowed because a flush happened while it was in flight.
    typedef struct packed {
        logic id;
        logic discard;
    } owner_entry_t;

    localparam logic REQ_PREFETCH  = 1'b0;
    localparam logic REQ_SECONDARY = 1'b1;

    // Unlocked grant choice: a lone requester wins; on a tie the requester
    // that did not win last time wins.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) begin
            return ~last;
        end
        return v1;
    endfunction

endpackage

// File: rtl/cv32e41s_instr_owner_fifo.sv
// In-order owner FIFO: one entry per accepted transaction, popped per response.
// Flush marks every stored entry as discard; an entry pushed in the flush
// cycle overwrites its slot and so stays unmarked.
module cv32e41s_instr_owner_fifo
    import cv32e41s_instr_obi_arbiter_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  owner_entry_t         push_data_i,
    input  logic                 pop_i,
    input  logic                 flush_i,
    output owner_entry_t         head_o,
    output logic                 empty_o,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    owner_entry_t         mem_q [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 push_en;
    logic                 pop_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Guard against overflow/underflow so the pointers can never desynchronise.
    always_comb begin
        push_en = push_i && (cnt_q != FULL_CNT);
        pop_en  = pop_i && (cnt_q != '0);
    end

    // Storage, pointers and occupancy. Marking free slots on flush is harmless
    // because a push always writes a fresh entry with discard cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i].discard <= 1'b1;
                end
            end
            if (pop_en) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push_en) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            case ({push_en, pop_en})
                2'b10:   cnt_q <= cnt_q + CNT_WIDTH'(1);
                2'b01:   cnt_q <= cnt_q - CNT_WIDTH'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/cv32e41s_instr_obi_arbiter.sv
// Shares the instruction OBI address channel between the prefetcher (0) and
// the secondary instruction-side master (1), and routes the in-order
// responses back to whoever issued each transaction.
//
// lock_q | meaning
// -------+-------------------------------------------------------------
//   0    | no address pending; grant follows round-robin selection
//   1    | lock_id_q has an offered, not yet accepted, address; grant held
module cv32e41s_instr_obi_arbiter
    import cv32e41s_instr_obi_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTND = 2,
    parameter int CNT_WIDTH   = $clog2(MAX_OUTSTND + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 r0_trans_valid_i,
    output logic                 r0_trans_ready_o,
    input  logic [31:0]          r0_trans_addr_i,
    output logic                 r0_resp_valid_o,

    input  logic                 r1_trans_valid_i,
    output logic                 r1_trans_ready_o,
    input  logic [31:0]          r1_trans_addr_i,
    output logic                 r1_resp_valid_o,

    input  logic                 flush_i,

    output logic                 trans_valid_o,
    input  logic                 trans_ready_i,
    output logic [31:0]          trans_addr_o,
    input  logic                 resp_valid_i,

    output logic [CNT_WIDTH-1:0] outstnd_cnt_o,
    output logic                 busy_o,
    output logic                 protocol_err_o
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTND);

    logic                 lock_q;
    logic                 lock_id_q;
    logic                 last_q;

    logic                 gnt;
    logic                 gnt_valid;
    logic [31:0]          gnt_addr;
    logic                 accept;
    logic                 pop;
    logic                 deliver;

    owner_entry_t         push_entry;
    owner_entry_t         head;
    logic                 fifo_empty;
    logic [CNT_WIDTH-1:0] cnt;

    // Grant selection: a pending offer keeps the grant, otherwise round-robin.
    always_comb begin
        gnt = rr_pick(r0_trans_valid_i, r1_trans_valid_i, last_q);
        if (lock_q) begin
            gnt = lock_id_q;
        end
        gnt_valid = (gnt == REQ_SECONDARY) ? r1_trans_valid_i : r0_trans_valid_i;
        gnt_addr  = (gnt == REQ_SECONDARY) ? r1_trans_addr_i  : r0_trans_addr_i;
    end

    // Address channel towards OBI. The outstanding limit uses the registered
    // count only, so a same-cycle response cannot reopen the channel early.
    always_comb begin
        trans_valid_o    = gnt_valid && (cnt < MAX_CNT);
        trans_addr_o     = trans_valid_o ? gnt_addr : 32'h0;
        accept           = trans_valid_o && trans_ready_i;
        r0_trans_ready_o = accept && (gnt == REQ_PREFETCH);
        r1_trans_ready_o = accept && (gnt == REQ_SECONDARY);
    end

    // Response routing from the registered FIFO head; a flush in the same
    // cycle swallows the response being popped.
    always_comb begin
        pop             = resp_valid_i && !fifo_empty;
        deliver         = pop && !head.discard && !flush_i;
        r0_resp_valid_o = deliver && (head.id == REQ_PREFETCH);
        r1_resp_valid_o = deliver && (head.id == REQ_SECONDARY);
        protocol_err_o  = resp_valid_i && fifo_empty;
        push_entry      = '{id: gnt, discard: 1'b0};
    end

    // Lock and round-robin history; flush deliberately leaves the lock alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_id_q <= REQ_PREFETCH;
            last_q    <= REQ_SECONDARY;
        end else if (accept) begin
            lock_q <= 1'b0;
            last_q <= gnt;
        end else if (trans_valid_o) begin
            lock_q    <= 1'b1;
            lock_id_q <= gnt;
        end
    end

    cv32e41s_instr_owner_fifo #(
        .DEPTH     (MAX_OUTSTND),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_owner_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (accept),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (flush_i),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .cnt_o       (cnt)
    );

    assign outstnd_cnt_o = cnt;
    assign busy_o        = (cnt != '0) || trans_valid_o;

endmodule

// File: tb/tb_cv32e41s_instr_obi_arbiter.sv
// Scoreboard bench for the instruction OBI arbiter: the driver computes the
// expected outputs of every cycle from a queue-based model and pushes them;
// an independent monitor pops and compares against the DUT.
module tb_cv32e41s_instr_obi_arbiter;

    localparam int MAX = 2;
    localparam int CW  = $clog2(MAX + 1);

    logic          clk;
    logic          rst_n;
    logic          r0_trans_valid_i, r1_trans_valid_i;
    logic [31:0]   r0_trans_addr_i, r1_trans_addr_i;
    logic          r0_trans_ready_o, r1_trans_ready_o;
    logic          r0_resp_valid_o, r1_resp_valid_o;
    logic          flush_i;
    logic          trans_valid_o;
    logic          trans_ready_i;
    logic [31:0]   trans_addr_o;
    logic          resp_valid_i;
    logic [CW-1:0] outstnd_cnt_o;
    logic          busy_o;
    logic          protocol_err_o;

    cv32e41s_instr_obi_arbiter #(.MAX_OUTSTND(MAX)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .r0_trans_valid_i (r0_trans_valid_i),
        .r0_trans_ready_o (r0_trans_ready_o),
        .r0_trans_addr_i  (r0_trans_addr_i),
        .r0_resp_valid_o  (r0_resp_valid_o),
        .r1_trans_valid_i (r1_trans_valid_i),
        .r1_trans_ready_o (r1_trans_ready_o),
        .r1_trans_addr_i  (r1_trans_addr_i),
        .r1_resp_valid_o  (r1_resp_valid_o),
        .flush_i          (flush_i),
        .trans_valid_o    (trans_valid_o),
        .trans_ready_i    (trans_ready_i),
        .trans_addr_o     (trans_addr_o),
        .resp_valid_i     (resp_valid_i),
        .outstnd_cnt_o    (outstnd_cnt_o),
        .busy_o           (busy_o),
        .protocol_err_o   (protocol_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: list of in-flight transactions plus the pending offer.
    typedef struct { bit id; bit disc; } own_t;
    own_t mq[$];
    bit   m_lock, m_lock_id, m_last;

    typedef struct {
        bit        tv;
        bit [31:0] addr;
        bit        r0rdy, r1rdy, r0rsp, r1rsp, perr, busy;
        int        cnt;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_lock    = 1'b0;
        m_lock_id = 1'b0;
        m_last    = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, predict, then advance model.
    task automatic cycle(input bit rst, input bit v0, input logic [31:0] a0,
                         input bit v1, input logic [31:0] a1,
                         input bit rdy, input bit rv, input bit fl);
        exp_t e;
        bit   g, gv, acc, deliver;
        @(negedge clk);
        rst_n            = !rst;
        r0_trans_valid_i = rst ? 1'b0 : v0;
        r0_trans_addr_i  = rst ? 32'h0 : a0;
        r1_trans_valid_i = rst ? 1'b0 : v1;
        r1_trans_addr_i  = rst ? 32'h0 : a1;
        trans_ready_i    = rst ? 1'b0 : rdy;
        resp_valid_i     = rst ? 1'b0 : rv;
        flush_i          = rst ? 1'b0 : fl;
        if (rst) begin
            model_reset();
            v0 = 0; v1 = 0; rdy = 0; rv = 0; fl = 0;
        end
        if (m_lock)        g = m_lock_id;
        else if (v0 && v1) g = !m_last;
        else               g = v1;
        gv      = g ? v1 : v0;
        e.tv    = gv && (mq.size() < MAX);
        e.addr  = e.tv ? (g ? a1 : a0) : 32'h0;
        acc     = e.tv && rdy;
        e.r0rdy = acc && !g;
        e.r1rdy = acc && g;
        e.cnt   = mq.size();
        e.perr  = rv && (mq.size() == 0);
        deliver = rv && (mq.size() > 0) && !mq[0].disc && !fl;
        e.r0rsp = deliver && !mq[0].id;
        e.r1rsp = deliver && mq[0].id;
        e.busy  = (e.cnt != 0) || e.tv;
        exp_q.push_back(e);
        if (!rst) begin
            if (fl) foreach (mq[i]) mq[i].disc = 1'b1;
            if (rv && mq.size() > 0) void'(mq.pop_front());
            if (acc) mq.push_back('{id: g, disc: 1'b0});
            if (acc) begin
                m_lock = 1'b0;
                m_last = g;
            end else if (e.tv) begin
                m_lock    = 1'b1;
                m_lock_id = g;
            end
        end
    endtask

    task automatic idle(input bit rv);
        cycle(0, 0, 0, 0, 0, 0, rv, 0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares every predicted cycle against the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_trans_valid", trans_valid_o, e.tv);
                chk("sb_trans_addr", trans_addr_o, e.addr);
                chk("sb_r0_ready", r0_trans_ready_o, e.r0rdy);
                chk("sb_r1_ready", r1_trans_ready_o, e.r1rdy);
                chk("sb_r0_resp", r0_resp_valid_o, e.r0rsp);
                chk("sb_r1_resp", r1_resp_valid_o, e.r1rsp);
                chk("sb_protocol_err", protocol_err_o, e.perr);
                chk("sb_cnt", outstnd_cnt_o, e.cnt);
                chk("sb_busy", busy_o, e.busy);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit        v0, v1, rdy, rv, fl, rst;
        bit [31:0] a0, a1;
        rst_n = 1'b0; r0_trans_valid_i = 0; r1_trans_valid_i = 0;
        r0_trans_addr_i = 0; r1_trans_addr_i = 0; trans_ready_i = 0;
        resp_valid_i = 0; flush_i = 0;
        model_reset();

        do_reset();
        #2 chk("reset_cnt", outstnd_cnt_o, 0);
        chk("reset_trans_valid", trans_valid_o, 0);
        chk("reset_busy", busy_o, 0);

        // Single prefetch transaction and its response.
        cycle(0, 1, 32'h80, 0, 0, 1, 0, 0);
        #2 chk("t1_trans_valid", trans_valid_o, 1);
        chk("t1_r0_ready", r0_trans_ready_o, 1);
        chk("t1_addr", trans_addr_o, 32'h80);
        idle(1);
        #2 chk("t1_cnt_one", outstnd_cnt_o, 1);
        chk("t1_r0_resp", r0_resp_valid_o, 1);
        idle(0);
        #2 chk("t1_cnt_zero", outstnd_cnt_o, 0);

        // Both requesters every cycle: grants alternate starting with 0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 32'h1000 + i, 1, 32'h2000 + i, 1, i > 0, 0);
            #2 chk("t2_grant_r1", r1_trans_ready_o, i % 2);
            if (i > 0) chk("t2_resp_r1", r1_resp_valid_o, (i - 1) % 2);
        end
        idle(1);
        #2 chk("t2_last_resp_r1", r1_resp_valid_o, 1);

        // Stalled r1 offer holds the grant; r0 follows.
        do_reset();
        cycle(0, 0, 0, 1, 32'hA1, 0, 0, 0);
        cycle(0, 1, 32'hB0, 1, 32'hA1, 0, 0, 0);
        #2 chk("t3_addr_held", trans_addr_o, 32'hA1);
        cycle(0, 1, 32'hB0, 1, 32'hA1, 0, 0, 0);
        #2 chk("t3_addr_held2", trans_addr_o, 32'hA1);
        cycle(0, 1, 32'hB0, 1, 32'hA1, 1, 0, 0);
        #2 chk("t3_r1_accept", r1_trans_ready_o, 1);
        cycle(0, 1, 32'hB0, 0, 0, 1, 1, 0);
        #2 chk("t3_r0_next", r0_trans_ready_o, 1);
        idle(1);

        // Outstanding limit: a response in cycle N reopens at N+1.
        do_reset();
        cycle(0, 1, 32'h10, 0, 0, 1, 0, 0);
        cycle(0, 1, 32'h14, 0, 0, 1, 0, 0);
        cycle(0, 1, 32'h18, 0, 0, 1, 0, 0);
        #2 chk("t4_full_blocked", trans_valid_o, 0);
        chk("t4_cnt_full", outstnd_cnt_o, 2);
        cycle(0, 1, 32'h18, 0, 0, 1, 1, 0);
        #2 chk("t4_no_reopen_same_cycle", trans_valid_o, 0);
        cycle(0, 1, 32'h18, 0, 0, 1, 0, 0);
        #2 chk("t4_reopen_next", trans_valid_o, 1);
        idle(1);
        idle(1);

        // Flush discards both in-flight responses; later r0 response delivered.
        do_reset();
        cycle(0, 1, 32'h20, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 32'h30, 1, 0, 0);
        cycle(0, 1, 32'h24, 0, 0, 1, 1, 1);
        #2 chk("t5_flush_resp_r0", r0_resp_valid_o, 0);
        chk("t5_flush_resp_r1", r1_resp_valid_o, 0);
        cycle(0, 1, 32'h24, 0, 0, 1, 1, 0);
        #2 chk("t5_old_resp_dropped", r1_resp_valid_o, 0);
        chk("t5_new_accept", r0_trans_ready_o, 1);
        idle(1);
        #2 chk("t5_new_resp_r0", r0_resp_valid_o, 1);
        // Entry pushed during the flush cycle is not marked.
        cycle(0, 1, 32'h40, 0, 0, 1, 0, 0);
        cycle(0, 1, 32'h44, 0, 0, 1, 0, 1);
        idle(1);
        #2 chk("t5b_old_dropped", r0_resp_valid_o, 0);
        idle(1);
        #2 chk("t5b_pushed_kept", r0_resp_valid_o, 1);

        // Response with nothing outstanding.
        idle(1);
        #2 chk("t6_protocol_err", protocol_err_o, 1);
        chk("t6_cnt_unchanged", outstnd_cnt_o, 0);
        idle(0);
        #2 chk("t6_err_single_cycle", protocol_err_o, 0);

        // Reset with transactions in flight.
        cycle(0, 1, 32'h50, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 32'h60, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("t7_reset_clears_cnt", outstnd_cnt_o, 0);
        idle(1);
        #2 chk("t7_late_resp_err", protocol_err_o, 1);

        // Randomised traffic honouring the OBI hold-while-offered rule.
        a0 = 0; a1 = 0; v0 = 0; v1 = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!(m_lock && m_lock_id == 1'b0)) begin
                v0 = ($urandom_range(0, 9) < 6);
                a0 = $urandom;
            end
            if (!(m_lock && m_lock_id == 1'b1)) begin
                v1 = ($urandom_range(0, 9) < 6);
                a1 = $urandom;
            end
            rdy = ($urandom_range(0, 9) < 7);
            rv  = (mq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            fl  = ($urandom_range(0, 11) == 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle(rst, v0, a0, v1, a1, rdy, rv, fl);
            if (rst) begin
                v0 = 0;
                v1 = 0;
            end
        end
        idle(0);

        repeat (3) @(negedge clk);
        #3 chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
